// File: rtl/keypad_pkg.sv
// Shared types, constants and the hit-vector decoder for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  // A scan result or debounced state: valid=0 means no key (or a rejected ghost).
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_t;

  localparam key_t KEY_NONE = '{valid: 1'b0, code: 4'h0};

  // Key map indexed {row, col}; nibble i holds the code for row i/4, column i%4.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  // Column currently driven low by the scanner.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_t;

  // One-hot hit vector -> key; zero or multiple hits give KEY_NONE.
  function automatic key_t decode_hits(input logic [NUM_KEYS-1:0] hits);
    key_t k;
    int   n;
    k = KEY_NONE;
    n = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (hits[i]) begin
        n++;
        k.code = KEY_MAP[i*4 +: 4];
      end
    end
    if (n == 1) k.valid = 1'b1;
    else        k = KEY_NONE;
    return k;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad matrix and key-event signals between the scanner and its neighbours.
// Outputs are plain registered levels; key_valid is a one-cycle strobe with no
// back-pressure: the consumer must accept it in the cycle it is high.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] disp_val;
  logic [1:0] scan_idx;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held, disp_val, scan_idx
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held, disp_val, scan_idx
  );
endinterface

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: the debounced state changes only after DEBOUNCE_SCANS
// consecutive identical scan results. state_next/change are valid in the
// scan_done cycle so the caller can register its outputs on the same edge.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic scan_done,
  input  key_t scan_result,
  output key_t state,
  output key_t state_next,
  output logic change
);

  localparam int             CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  key_t          prev;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] cnt_next;

  // Next match count and whether this scan commits a new debounced state.
  always_comb begin
    cnt_next   = match_cnt;
    change     = 1'b0;
    state_next = state;
    if (scan_done) begin
      if (scan_result == prev)
        cnt_next = (match_cnt == CNT_MAX) ? CNT_MAX : match_cnt + 1'b1;
      else
        cnt_next = CW'(1);
      if (cnt_next == CNT_MAX && scan_result != state) begin
        change     = 1'b1;
        state_next = scan_result;
      end
    end
  end

  // Debounce registers advance once per completed scan.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev      <= KEY_NONE;
      match_cnt <= '0;
      state     <= KEY_NONE;
    end else if (scan_done) begin
      prev      <= scan_result;
      match_cnt <= cnt_next;
      state     <= state_next;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchroniser, hit collection, scan
// decode, debounce and key-event outputs.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic      clock,
  input logic      reset,
  keypad_if.master kp
);

  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]          row_meta, row_sync;
  logic [DW-1:0]       dwell;
  col_state_t          col_state, col_next;
  logic [3:0]          col_q;
  logic [NUM_KEYS-1:0] hits, hits_sampled, hits_full;
  logic                sample_pend;
  logic                last_dwell;
  key_t                scan_result;
  logic                scan_done;
  key_t                deb_state, deb_next;
  logic                deb_change;
  logic [3:0]          key_code_q, disp_val_q;
  logic                key_valid_q;

  // Two-flop synchroniser on the asynchronous row inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
    end
  end

  assign last_dwell = (dwell == DWELL_LAST);

  // Column sequence advances only at the end of each dwell period.
  always_comb begin
    col_next = col_state;
    if (last_dwell) begin
      case (col_state)
        COL0:    col_next = COL1;
        COL1:    col_next = COL2;
        COL2:    col_next = COL3;
        default: col_next = COL0;
      endcase
    end
  end

  // Hit vector with the current column's synchronised rows merged in (active-low).
  always_comb begin
    hits_sampled = hits;
    for (int r = 0; r < NUM_ROWS; r++)
      hits_sampled[r*NUM_COLS + int'(col_state)] = ~row_sync[r];
  end

  // Scan FSM: dwell counter, column drive, per-column sampling, scan hand-off.
  // col is loaded from the next column so it lines up with col_state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell       <= '0;
      col_state   <= COL0;
      col_q       <= 4'b1111;
      hits        <= '0;
      hits_full   <= '0;
      sample_pend <= 1'b0;
    end else begin
      sample_pend <= 1'b0;
      dwell       <= last_dwell ? '0 : dwell + 1'b1;
      col_state   <= col_next;
      col_q       <= ~(4'b0001 << col_next);
      if (last_dwell) begin
        if (col_state == COL3) begin
          hits_full   <= hits_sampled;
          hits        <= '0;
          sample_pend <= 1'b1;
        end else begin
          hits <= hits_sampled;
        end
      end
    end
  end

  // Scan result register: decode the completed hit vector.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_result <= KEY_NONE;
      scan_done   <= 1'b0;
    end else begin
      scan_done <= sample_pend;
      if (sample_pend) scan_result <= decode_hits(hits_full);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .scan_done  (scan_done),
    .scan_result(scan_result),
    .state      (deb_state),
    .state_next (deb_next),
    .change     (deb_change)
  );

  // Key event outputs, registered on the same edge the debounced state changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_code_q  <= 4'h0;
      disp_val_q  <= 4'hF;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (deb_change && deb_next.valid) begin
        key_valid_q <= 1'b1;
        key_code_q  <= deb_next.code;
        disp_val_q  <= deb_next.code;
      end
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = deb_state.valid;
  assign kp.disp_val  = disp_val_q;
  assign kp.scan_idx  = col_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix model driven from col, a scan-level
// reference model, and one task per scenario.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;

  keypad_if kp();

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kp   (kp.master)
  );

  always #5 clock = ~clock;

  // ---------------- matrix model ----------------
  logic [15:0] pressed = 16'h0;
  logic [3:0]  row_drv;

  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col[c]) row_drv[r] = 1'b0;
  end
  assign kp.row = row_drv;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [3:0] pulse_codes[$];
  string key_chars = "123A456B789C0FED";

  // ---------------- reference model (scan granularity) ----------------
  int m_prev, m_cnt, m_deb, m_disp, m_code, m_held;
  bit m_pend;

  function automatic int char_val(input byte ch);
    int v;
    v = int'(ch);
    if (v >= 48 && v <= 57) return v - 48;
    return v - 55;
  endfunction

  function automatic int key_pos(input int code);
    for (int i = 0; i < 16; i++)
      if (char_val(key_chars.getc(i)) == code) return i;
    return 0;
  endfunction

  function automatic logic [15:0] key_mask(input int code);
    logic [15:0] m;
    m = 16'h1;
    return m << key_pos(code);
  endfunction

  task automatic model_reset();
    m_prev = -1; m_cnt = 0; m_deb = -1;
    m_disp = 15; m_code = 0; m_held = 0; m_pend = 1'b0;
  endtask

  task automatic model_step(input logic [15:0] p);
    int res;
    res = -1;
    if ($countones(p) == 1)
      for (int i = 0; i < 16; i++) if (p[i]) res = char_val(key_chars.getc(i));
    if (res == m_prev) m_cnt = (m_cnt >= DEB) ? DEB : m_cnt + 1;
    else               m_cnt = 1;
    m_prev = res;
    m_pend = 1'b0;
    if (m_cnt == DEB && res != m_deb) begin
      m_deb = res;
      if (res >= 0) begin
        m_pend = 1'b1; m_code = res; m_disp = res; m_held = 1;
      end else begin
        m_held = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One full scan starting at the negedge just after the col3->col0 wrap.
  task automatic do_scan(input logic [15:0] p);
    logic [3:0] exp_col;
    logic       exp_v;
    pressed = p;
    for (int k = 0; k < SCAN_CYC; k++) begin
      exp_col = ~(4'b0001 << (k / SCAN_DIV));
      checks++;
      if (kp.col !== exp_col) begin
        errors++; $display("FAIL col k=%0d: got %b expected %b", k, kp.col, exp_col);
      end
      exp_v = (k == 2) && m_pend;
      checks++;
      if (kp.key_valid !== exp_v) begin
        errors++; $display("FAIL key_valid k=%0d: got %b expected %b", k, kp.key_valid, exp_v);
      end
      if (kp.key_valid === 1'b1) begin
        pulse_cnt++;
        pulse_codes.push_back(kp.key_code);
      end
      if (k == 3) begin
        checks++;
        if (kp.key_code !== 4'(m_code)) begin
          errors++; $display("FAIL key_code: got %h expected %h", kp.key_code, 4'(m_code));
        end
        checks++;
        if (kp.disp_val !== 4'(m_disp)) begin
          errors++; $display("FAIL disp_val: got %h expected %h", kp.disp_val, 4'(m_disp));
        end
        checks++;
        if (kp.key_held !== 1'(m_held)) begin
          errors++; $display("FAIL key_held: got %b expected %b", kp.key_held, 1'(m_held));
        end
      end
      @(negedge clock);
    end
    model_step(p);
  endtask

  // Wait for the first wrap after reset; that first scan sees keys p.
  task automatic sync_scan(input logic [15:0] p);
    logic [3:0] prev_col;
    bit found;
    pressed = p;
    found = 1'b0;
    prev_col = kp.col;
    for (int n = 0; n < 3 * SCAN_CYC && !found; n++) begin
      @(negedge clock);
      checks++;
      if (kp.key_valid !== 1'b0) begin
        errors++; $display("FAIL sync key_valid: got %b expected 0", kp.key_valid);
      end
      if (kp.col == 4'b1110 && prev_col == 4'b0111) found = 1'b1;
      prev_col = kp.col;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL sync wrap: got no wrap expected wrap within %0d cycles", 3 * SCAN_CYC);
    end
    model_reset();
    model_step(p);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (kp.col !== 4'b1111) begin errors++; $display("FAIL %s col: got %b expected 1111", tag, kp.col); end
    checks++;
    if (kp.key_code !== 4'h0) begin errors++; $display("FAIL %s key_code: got %h expected 0", tag, kp.key_code); end
    checks++;
    if (kp.key_valid !== 1'b0) begin errors++; $display("FAIL %s key_valid: got %b expected 0", tag, kp.key_valid); end
    checks++;
    if (kp.key_held !== 1'b0) begin errors++; $display("FAIL %s key_held: got %b expected 0", tag, kp.key_held); end
    checks++;
    if (kp.disp_val !== 4'hF) begin errors++; $display("FAIL %s disp_val: got %h expected F", tag, kp.disp_val); end
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    check_reset_values("release");
    @(posedge clock);
    #1;
    checks++;
    if (kp.col !== 4'b1110) begin errors++; $display("FAIL first_col: got %b expected 1110", kp.col); end
  endtask

  task automatic release_all();
    for (int i = 0; i < 4; i++) do_scan(16'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int p0;
    pressed = 16'h0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 check_reset_values("por");
    release_reset();
    sync_scan(16'h0);
    for (int i = 0; i < 4; i++) do_scan(key_mask(7));
    checks++;
    if (kp.disp_val !== 4'h7) begin errors++; $display("FAIL pre_reset disp: got %h expected 7", kp.disp_val); end
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    repeat (2) @(posedge clock);
    #1 check_reset_values("held");
    release_reset();
    p0 = pulse_cnt;
    sync_scan(key_mask(7));
    for (int i = 0; i < 3; i++) do_scan(key_mask(7));
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL reset_repress pulses: got %0d expected 1", pulse_cnt - p0); end
  endtask

  task automatic test_press_hold();
    int p0;
    release_all();
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) do_scan(key_mask(5));
    checks++;
    if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL hold pulses: got %0d expected 1", pulse_cnt - p0); end
    checks++;
    if (kp.key_code !== 4'h5 || kp.disp_val !== 4'h5 || kp.key_held !== 1'b1) begin
      errors++; $display("FAIL hold outputs: got %h/%h/%b expected 5/5/1", kp.key_code, kp.disp_val, kp.key_held);
    end
    for (int i = 0; i < 4; i++) do_scan(16'h0);
    checks++;
    if (kp.key_held !== 1'b0 || kp.disp_val !== 4'h5) begin
      errors++; $display("FAIL release outputs: got held %b disp %h expected 0/5", kp.key_held, kp.disp_val);
    end
  endtask

  task automatic test_bounce();
    int p0;
    release_all();
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) do_scan((i % 2 == 0) ? key_mask(9) : 16'h0);
    checks++;
    if (pulse_cnt !== p0) begin errors++; $display("FAIL bounce pulses: got %0d expected 0", pulse_cnt - p0); end
    for (int i = 0; i < 4; i++) do_scan(key_mask(9));
    checks++;
    if (pulse_cnt - p0 !== 1 || pulse_codes[$] !== 4'h9) begin
      errors++; $display("FAIL bounce settle: got %0d pulses code %h expected 1 code 9", pulse_cnt - p0, pulse_codes[$]);
    end
  endtask

  task automatic test_ghosting();
    int p0;
    release_all();
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) do_scan(key_mask(1) | key_mask(2));
    checks++;
    if (pulse_cnt !== p0 || kp.key_held !== 1'b0) begin
      errors++; $display("FAIL ghost: got %0d pulses held %b expected 0/0", pulse_cnt - p0, kp.key_held);
    end
    for (int i = 0; i < 4; i++) do_scan(key_mask(1));
    checks++;
    if (pulse_cnt - p0 !== 1 || pulse_codes[$] !== 4'h1) begin
      errors++; $display("FAIL ghost release: got %0d pulses code %h expected 1 code 1", pulse_cnt - p0, pulse_codes[$]);
    end
  endtask

  task automatic test_direct_change();
    int p0;
    release_all();
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) do_scan(key_mask(10));
    for (int i = 0; i < 4; i++) do_scan(key_mask(11));
    checks++;
    if (pulse_cnt - p0 !== 2 || pulse_codes[$-1] !== 4'hA || pulse_codes[$] !== 4'hB) begin
      errors++; $display("FAIL direct: got %0d pulses %h,%h expected 2 A,B", pulse_cnt - p0, pulse_codes[$-1], pulse_codes[$]);
    end
  endtask

  task automatic test_blank();
    int p0;
    release_all();
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) do_scan(key_mask(15));
    checks++;
    if (pulse_cnt - p0 !== 1 || kp.disp_val !== 4'hF || kp.key_code !== 4'hF) begin
      errors++; $display("FAIL blank: got %0d pulses disp %h expected 1 disp F", pulse_cnt - p0, kp.disp_val);
    end
  endtask

  task automatic test_sweep();
    int p0;
    release_all();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        logic [15:0] m;
        logic [3:0]  exp_code;
        m = 16'h1;
        m = m << (r * 4 + c);
        exp_code = 4'(char_val(key_chars.getc(r * 4 + c)));
        p0 = pulse_cnt;
        for (int i = 0; i < 3; i++) do_scan(m);
        for (int i = 0; i < 3; i++) do_scan(16'h0);
        checks++;
        if (pulse_cnt - p0 !== 1 || pulse_codes[$] !== exp_code) begin
          errors++; $display("FAIL sweep r%0d c%0d: got %0d pulses code %h expected 1 code %h", r, c, pulse_cnt - p0, pulse_codes[$], exp_code);
        end
      end
    end
  endtask

  task automatic test_random();
    int          remaining;
    int          mode, a, b;
    logic [15:0] cur, one;
    remaining = 0;
    cur = 16'h0;
    one = 16'h1;
    for (int s = 0; s < 60; s++) begin
      if (remaining == 0) begin
        mode = $urandom_range(0, 3);
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        case (mode)
          1:       cur = 16'h0;
          2:       cur = one << a;
          3:       cur = (one << a) | (one << b);
          default: cur = cur;
        endcase
        remaining = $urandom_range(1, 5);
      end
      do_scan(cur);
      remaining--;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    test_reset();
    test_press_hold();
    test_bounce();
    test_ghosting();
    test_direct_change();
    test_blank();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
